// File: rtl/pwm_ramp_sequencer.sv
// Ramps a bank of PWM duty registers toward host-posted targets, one channel per cycle
// on every prescaler tick, and is the sole writer of the bank's strobe/address/data port.
module pwm_ramp_sequencer #(
    parameter int Resolution    = 8,
    parameter int AddressWidth  = 2,
    parameter int PrescaleWidth = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [AddressWidth-1:0]        cmd_addr,
    input  logic [Resolution-1:0]          cmd_target,
    input  logic [Resolution-1:0]          cmd_step,
    input  logic                           cmd_immediate,
    input  logic [PrescaleWidth-1:0]       prescale,
    output logic                           pwm_ce,
    output logic [AddressWidth-1:0]        pwm_addr,
    output logic [Resolution-1:0]          pwm_D,
    output logic                           busy,
    output logic [(2**AddressWidth)-1:0]   done
);

    localparam int Channels = 2 ** AddressWidth;
    localparam logic [AddressWidth-1:0] LastCh  = AddressWidth'(Channels - 1);
    localparam logic [Resolution-1:0]   OneDuty = Resolution'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IMM_WR = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [PrescaleWidth-1:0] count_q, count_d;
    logic                     pending_q, pending_d;
    logic                     run_q;
    logic [AddressWidth-1:0]  ch_q, ch_d;
    logic [Resolution-1:0]    current_q [Channels];
    logic [Resolution-1:0]    current_d [Channels];
    logic [Resolution-1:0]    target_q  [Channels];
    logic [Resolution-1:0]    target_d  [Channels];
    logic [Resolution-1:0]    step_q    [Channels];
    logic [Resolution-1:0]    step_d    [Channels];
    logic                     pwm_ce_q, pwm_ce_d;
    logic [AddressWidth-1:0]  pwm_addr_q, pwm_addr_d;
    logic [Resolution-1:0]    pwm_data_q, pwm_data_d;
    logic [Channels-1:0]      done_q, done_d;

    logic                     tick;
    logic                     accept;
    logic [Resolution-1:0]    step_eff;
    logic [Resolution-1:0]    cur_ch, tgt_ch, stp_ch, diff, next_duty;

    assign cmd_ready = run_q && (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q == S_UPDATE) || (state_q == S_IMM_WR);
    assign pwm_ce    = pwm_ce_q;
    assign pwm_addr  = pwm_addr_q;
    assign pwm_D     = pwm_data_q;
    assign done      = done_q;

    // Compare-before-subtract so the step saturates at target and never wraps the duty range.
    always_comb begin
        cur_ch    = current_q[ch_q];
        tgt_ch    = target_q[ch_q];
        stp_ch    = step_q[ch_q];
        diff      = '0;
        next_duty = cur_ch;
        if (cur_ch < tgt_ch) begin
            diff      = tgt_ch - cur_ch;
            next_duty = (diff <= stp_ch) ? tgt_ch : cur_ch + stp_ch;
        end else if (cur_ch > tgt_ch) begin
            diff      = cur_ch - tgt_ch;
            next_duty = (diff <= stp_ch) ? tgt_ch : cur_ch - stp_ch;
        end
    end

    always_comb begin
        tick       = (count_q >= prescale);
        count_d    = tick ? '0 : count_q + 1'b1;
        step_eff   = (cmd_step == '0) ? OneDuty : cmd_step;
        state_d    = state_q;
        pending_d  = pending_q;
        ch_d       = ch_q;
        current_d  = current_q;
        target_d   = target_q;
        step_d     = step_q;
        pwm_ce_d   = 1'b0;
        pwm_addr_d = pwm_addr_q;
        pwm_data_d = pwm_data_q;

        case (state_q)
            S_IDLE: begin
                // A command always wins the cycle; a coincident tick is owed as a pending scan.
                if (accept) begin
                    target_d[cmd_addr] = cmd_target;
                    step_d[cmd_addr]   = step_eff;
                    if (tick) begin
                        pending_d = 1'b1;
                    end
                    if (cmd_immediate) begin
                        current_d[cmd_addr] = cmd_target;
                        pwm_ce_d            = 1'b1;
                        pwm_addr_d          = cmd_addr;
                        pwm_data_d          = cmd_target;
                        state_d             = S_IMM_WR;
                    end
                end else if (tick || pending_q) begin
                    pending_d = 1'b0;
                    ch_d      = '0;
                    state_d   = S_UPDATE;
                end
            end
            S_IMM_WR: begin
                if (tick) begin
                    pending_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_UPDATE: begin
                if (tick) begin
                    pending_d = 1'b1;
                end
                if (cur_ch != tgt_ch) begin
                    current_d[ch_q] = next_duty;
                    pwm_ce_d        = 1'b1;
                    pwm_addr_d      = ch_q;
                    pwm_data_d      = next_duty;
                end
                if (ch_q == LastCh) begin
                    state_d = S_IDLE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < Channels; i++) begin
            done_d[i] = (current_q[i] == target_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            pending_q  <= 1'b0;
            run_q      <= 1'b0;
            ch_q       <= '0;
            pwm_ce_q   <= 1'b0;
            pwm_addr_q <= '0;
            pwm_data_q <= '0;
            done_q     <= '1;
            for (int i = 0; i < Channels; i++) begin
                current_q[i] <= '0;
                target_q[i]  <= '0;
                step_q[i]    <= OneDuty;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            run_q      <= 1'b1;
            ch_q       <= ch_d;
            pwm_ce_q   <= pwm_ce_d;
            pwm_addr_q <= pwm_addr_d;
            pwm_data_q <= pwm_data_d;
            done_q     <= done_d;
            current_q  <= current_d;
            target_q   <= target_d;
            step_q     <= step_d;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: expected duty writes are queued when commands are
// issued and matched against every pwm_ce strobe seen on the falling clock edge.
module tb_pwm_ramp_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_addr = '0;
    logic [7:0]  cmd_target = '0;
    logic [7:0]  cmd_step = '0;
    logic        cmd_immediate = 1'b0;
    logic [15:0] prescale = 16'd7;
    logic        pwm_ce;
    logic [1:0]  pwm_addr;
    logic [7:0]  pwm_D;
    logic        busy;
    logic [3:0]  done;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [9:0]  exp_q [$];
    int          wr_cycles [$];

    pwm_ramp_sequencer #(
        .Resolution    (8),
        .AddressWidth  (2),
        .PrescaleWidth (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_target    (cmd_target),
        .cmd_step      (cmd_step),
        .cmd_immediate (cmd_immediate),
        .prescale      (prescale),
        .pwm_ce        (pwm_ce),
        .pwm_addr      (pwm_addr),
        .pwm_D         (pwm_D),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe must match the oldest queued write; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (pwm_ce === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("[TB] FAIL unexpected_write observed=%0h_%0h expected=none", pwm_addr, pwm_D);
            end
            if (exp_q.size() != 0) begin
                logic [9:0] e;
                e = exp_q.pop_front();
                assert ({pwm_addr, pwm_D} === e) else begin
                    failures++;
                    $error("[TB] FAIL write observed=%0h_%0h expected=%0h_%0h",
                           pwm_addr, pwm_D, e[9:8], e[7:0]);
                end
            end
            wr_cycles.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] t, input logic [7:0] s,
                                 input logic imm, input logic tick_now);
        int          waited;
        logic [15:0] saved;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid     = 1'b1;
        cmd_addr      = a;
        cmd_target    = t;
        cmd_step      = s;
        cmd_immediate = imm;
        saved         = prescale;
        if (tick_now) prescale = 16'd0;
        @(posedge clk); #1;
        cmd_valid     = 1'b0;
        cmd_immediate = 1'b0;
        prescale      = saved;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int stable;
        int n;
        stable = 0;
        n = 0;
        while (stable < 12 && n < limit) begin
            @(posedge clk); #1;
            n++;
            if (exp_q.size() == 0 && done === 4'hF) stable++;
            else stable = 0;
        end
        checks++;
        assert (stable >= 12) else begin
            failures++;
            $error("[TB] FAIL %s observed=pending_%0d expected=pending_0", tag, exp_q.size());
        end
    endtask

    initial begin
        $display("[TB] start");
        #23;
        checkOutput("reset_pwm_ce", {31'd0, pwm_ce}, 32'd0);
        checkOutput("reset_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("reset_done", {28'd0, done}, 32'hF);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_release", {31'd0, cmd_ready}, 32'd1);

        $display("[TB] ramp up ch1");
        wr_cycles.delete();
        exp_q.push_back({2'd1, 8'd4});
        exp_q.push_back({2'd1, 8'd8});
        exp_q.push_back({2'd1, 8'd10});
        applyStimulus(2'd1, 8'd10, 8'd4, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("done1_clear", {31'd0, done[1]}, 32'd0);
        waitIdle("ramp_up_settle", 200);
        checkOutput("ramp_up_writes", wr_cycles.size(), 32'd3);
        if (wr_cycles.size() == 3) begin
            checkOutput("scan_spacing_a", wr_cycles[1] - wr_cycles[0], 32'd8);
            checkOutput("scan_spacing_b", wr_cycles[2] - wr_cycles[1], 32'd8);
        end
        checkOutput("ramp_up_done", {28'd0, done}, 32'hF);

        $display("[TB] ramp down ch2 with saturation");
        exp_q.push_back({2'd2, 8'd200});
        applyStimulus(2'd2, 8'd200, 8'd1, 1'b1, 1'b0);
        exp_q.push_back({2'd2, 8'd100});
        exp_q.push_back({2'd2, 8'd5});
        applyStimulus(2'd2, 8'd5, 8'd100, 1'b0, 1'b0);
        waitIdle("ramp_down_settle", 200);

        $display("[TB] step 0 to end of range on ch0");
        prescale = 16'd0;
        for (int v = 1; v <= 255; v++) exp_q.push_back({2'd0, 8'(v)});
        applyStimulus(2'd0, 8'd255, 8'd0, 1'b0, 1'b0);
        waitIdle("step0_settle", 3000);
        prescale = 16'd7;

        $display("[TB] immediate write ch3");
        exp_q.push_back({2'd3, 8'h80});
        applyStimulus(2'd3, 8'h80, 8'd1, 1'b1, 1'b0);
        checkOutput("imm_ce", {31'd0, pwm_ce}, 32'd1);
        checkOutput("imm_addr", {30'd0, pwm_addr}, 32'd3);
        checkOutput("imm_data", {24'd0, pwm_D}, 32'h80);
        checkOutput("imm_busy", {31'd0, busy}, 32'd1);
        checkOutput("imm_ready_low", {31'd0, cmd_ready}, 32'd0);
        waitIdle("imm_settle", 100);

        $display("[TB] command and tick in the same cycle");
        prescale = 16'd1000;
        applyStimulus(2'd2, 8'd25, 8'd10, 1'b0, 1'b0);
        wr_cycles.delete();
        exp_q.push_back({2'd3, 8'h40});
        exp_q.push_back({2'd2, 8'd15});
        applyStimulus(2'd3, 8'h40, 8'd1, 1'b1, 1'b1);
        repeat (30) begin @(posedge clk); #1; end
        checkOutput("collision_queue_empty", exp_q.size(), 32'd0);
        checkOutput("collision_writes", wr_cycles.size(), 32'd2);
        if (wr_cycles.size() == 2) begin
            checkOutput("collision_latency", wr_cycles[1] - wr_cycles[0], 32'd5);
        end
        checkOutput("collision_done", {28'd0, done}, 32'hB);

        $display("[TB] reset in the middle of a scan");
        prescale = 16'd0;
        begin
            int n;
            n = 0;
            while (busy !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("scan_started", {31'd0, busy}, 32'd1);
        end
        rst = 1'b0;
        #1;
        checkOutput("abort_pwm_ce", {31'd0, pwm_ce}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("abort_done", {28'd0, done}, 32'hF);
        repeat (3) begin @(posedge clk); #1; end
        prescale = 16'd7;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({2'd2, 8'd1});
        exp_q.push_back({2'd2, 8'd2});
        exp_q.push_back({2'd2, 8'd3});
        applyStimulus(2'd2, 8'd3, 8'd0, 1'b0, 1'b0);
        waitIdle("post_reset_settle", 200);
        checkOutput("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
